// File: rtl/add_sub_serial_if.sv
// Operand/result handshake bundle for add_sub_serial.
// The slave modport is the arithmetic block; master is whoever stages operands
// and consumes results.
interface add_sub_serial_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         acc_en;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         carry;
    logic         ovf;
    logic         zero;

    modport slave (
        input  in_valid, a, b, sub, acc_en, out_ready,
        output in_ready, out_valid, sum, carry, ovf, zero
    );

    modport master (
        output in_valid, a, b, sub, acc_en, out_ready,
        input  in_ready, out_valid, sum, carry, ovf, zero
    );
endinterface

// File: rtl/add_sub_serial.sv
// Multi-cycle two's-complement adder/subtractor, K bits per clock over
// N-bit operands, with carry/overflow/zero flags and an accumulate mode.
// Subtraction is A + ~B + 1: B is inverted at accept and the initial carry
// is seeded with the sub bit.
module add_sub_serial #(
    parameter int N = 8,
    parameter int K = 2
) (
    input logic             clk,
    input logic             rst,
    add_sub_serial_if.slave bus
);
    localparam int STEPS = N / K;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  acc;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic          c;
    logic [N-1:0]  res;

    logic [N-1:0]  sum_q;
    logic          carry_q;
    logic          ovf_q;
    logic          zero_q;

    logic [K:0]     chunk;
    logic [N+K-1:0] res_cat;
    logic [N-1:0]   res_next;
    logic           msb_cin;
    logic           accept;
    logic           last_step;

    assign accept    = (state == IDLE) && bus.in_valid;
    assign last_step = (state == RUN) && (cnt == LAST);

    // K-bit chunk adder plus result shift; concatenation keeps K == N legal
    always_comb begin
        chunk    = {1'b0, op_a[K-1:0]} + {1'b0, op_b[K-1:0]} + {{K{1'b0}}, c};
        res_cat  = {chunk[K-1:0], res};
        res_next = res_cat[N+K-1:K];
        // carry into the MSB recovered from the MSB sum bit of the final chunk
        msb_cin  = op_a[K-1] ^ op_b[K-1] ^ chunk[K-1];
    end

    // Control FSM and chunk counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand capture at accept, then right-shifting by K each RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
            c    <= 1'b0;
            res  <= '0;
        end else if (accept) begin
            op_a <= bus.acc_en ? acc : bus.a;
            op_b <= bus.b ^ {N{bus.sub}};
            c    <= bus.sub;
        end else if (state == RUN) begin
            op_a <= op_a >> K;
            op_b <= op_b >> K;
            c    <= chunk[K];
            res  <= res_next;
        end
    end

    // Result and flags latched when the last chunk completes
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (last_step) begin
            sum_q   <= res_next;
            carry_q <= chunk[K];
            ovf_q   <= msb_cin ^ chunk[K];
            zero_q  <= (res_next == '0);
        end
    end

    // Accumulator follows the delivered result on the output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if ((state == DONE) && bus.out_ready) begin
            acc <= sum_q;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule
